nabp_filtered_ring_buffer: RTL and testbench

N-bank ring of filtered-projection line buffers. It sits between the FIR filter and the processing swap control, and generalises the fixed two-bank filtered RAM swap to NUM_BANKS banks and NUM_READERS read ports. The filter fills banks one angle at a time, in ring order. The processing side consumes full banks in the same FIFO order, using a current/previous window so that two angles can be read in overlap.

---
 rtl/nabp_filtered_ring_buffer_pkg.sv | 24 ++
 rtl/nabp_line_bank.sv | 31 +++
 rtl/nabp_filtered_ring_buffer.sv | 187 ++++++++++++++++++
 tb/tb_nabp_filtered_ring_buffer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nabp_filtered_ring_buffer_pkg.sv
// Shared types, widths and helpers for the filtered-projection ring buffer.
package nabp_filtered_ring_buffer_pkg;

  localparam int unsigned kNoOfS              = 256;
  localparam int unsigned kFilteredDataLength = 16;
  localparam int unsigned kAngleLength        = 9;

  typedef enum logic [2:0] {
    BankFree,
    BankFill,
    BankFull,
    BankCur,
    BankPrev
  } bank_state_e;

  // Index width for a count of items; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/nabp_line_bank.sv
// One projection line store: single write port, NUM_READERS registered read ports.
module nabp_line_bank
  import nabp_filtered_ring_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = kNoOfS,
  parameter int unsigned DATA_W      = kFilteredDataLength,
  parameter int unsigned NUM_READERS = 2,
  localparam int unsigned AW         = clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [AW-1:0]                 i_waddr,
  input  logic [DATA_W-1:0]             i_wdata,
  input  logic [NUM_READERS*AW-1:0]     i_raddr,
  output logic [NUM_READERS*DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0]             r_mem [DEPTH];
  logic [NUM_READERS*DATA_W-1:0] r_rdata;

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    for (int r = 0; r < NUM_READERS; r++) begin
      r_rdata[r*DATA_W +: DATA_W] <= r_mem[i_raddr[r*AW +: AW]];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/nabp_filtered_ring_buffer.sv
// N-bank FIFO ring of filtered line buffers between the FIR filter and the
// processing side, with a current/previous read window for overlapped angles.
module nabp_filtered_ring_buffer
  import nabp_filtered_ring_buffer_pkg::*;
#(
  parameter int unsigned NUM_BANKS   = 3,
  parameter int unsigned DEPTH       = kNoOfS,
  parameter int unsigned DATA_W      = kFilteredDataLength,
  parameter int unsigned ANGLE_W     = kAngleLength,
  parameter int unsigned NUM_READERS = 2,
  localparam int unsigned AW         = clog2(DEPTH),
  localparam int unsigned BW         = clog2(NUM_BANKS)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          hs_start,
  input  logic [ANGLE_W-1:0]            hs_angle,
  output logic                          hs_start_ack,
  input  logic                          hs_valid,
  input  logic [DATA_W-1:0]             hs_val,
  output logic [AW-1:0]                 hs_s_val,
  output logic                          hs_line_done,
  output logic                          pr_has_next_angle,
  output logic [ANGLE_W-1:0]            pr_angle,
  input  logic                          pr_next_angle,
  output logic                          pr_next_angle_ack,
  input  logic                          pr_prev_angle_release,
  output logic                          pr_prev_angle_release_ack,
  input  logic [NUM_READERS*AW-1:0]     pr_s_val,
  input  logic [NUM_READERS-1:0]        pr_sel_prev,
  output logic [NUM_READERS*DATA_W-1:0] pr_val
);

  bank_state_e          r_state [NUM_BANKS];
  bank_state_e          w_state_d [NUM_BANKS];
  logic [ANGLE_W-1:0]   r_tag [NUM_BANKS];
  logic [BW-1:0]        r_wp, w_wp_d, r_rp, w_rp_d;
  logic [BW-1:0]        r_cur, w_cur_d, r_prev, w_prev_d;
  logic                 r_cur_vld, w_cur_vld_d, r_prev_vld, w_prev_vld_d;
  logic                 r_filling, w_filling_d;
  logic [AW-1:0]        r_s_val, w_s_val_d;
  logic                 r_start_ack, w_start_ack_d;
  logic                 r_next_ack, w_next_ack_d;
  logic                 r_rel_ack, w_rel_ack_d;
  logic                 w_wr, w_last;
  logic [NUM_BANKS-1:0] w_we;

  logic [BW-1:0]                 r_rd_bank [NUM_READERS];
  logic [NUM_READERS-1:0]        r_rd_ok;
  logic [NUM_READERS*DATA_W-1:0] w_bank_rdata [NUM_BANKS];

  function automatic logic [BW-1:0] ring_inc(input logic [BW-1:0] p);
    return (p == BW'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_wr   = r_filling && hs_valid;
  assign w_last = w_wr && (r_s_val == AW'(DEPTH - 1));

  always_comb begin
    w_state_d     = r_state;
    w_wp_d        = r_wp;
    w_rp_d        = r_rp;
    w_cur_d       = r_cur;
    w_cur_vld_d   = r_cur_vld;
    w_prev_d      = r_prev;
    w_prev_vld_d  = r_prev_vld;
    w_filling_d   = r_filling;
    w_s_val_d     = r_s_val;
    w_start_ack_d = 1'b0;
    w_next_ack_d  = 1'b0;
    w_rel_ack_d   = 1'b0;

    // Release is applied first so a same-cycle take sees the freed window slot.
    if (pr_prev_angle_release) begin
      w_rel_ack_d = 1'b1;
      if (r_prev_vld) begin
        w_state_d[r_prev] = BankFree;
        w_prev_vld_d      = 1'b0;
      end
    end

    if (pr_next_angle && (r_state[r_rp] == BankFull) && !w_prev_vld_d) begin
      w_next_ack_d = 1'b1;
      if (r_cur_vld) begin
        w_state_d[r_cur] = BankPrev;
        w_prev_d         = r_cur;
        w_prev_vld_d     = 1'b1;
      end
      w_state_d[r_rp] = BankCur;
      w_cur_d         = r_rp;
      w_cur_vld_d     = 1'b1;
      w_rp_d          = ring_inc(r_rp);
    end

    if (r_filling) begin
      if (w_last) begin
        w_state_d[r_wp] = BankFull;
        w_wp_d          = ring_inc(r_wp);
        w_s_val_d       = '0;
        w_filling_d     = 1'b0;
      end else if (w_wr) begin
        w_s_val_d = r_s_val + 1'b1;
      end
    end else if (hs_start && (r_state[r_wp] == BankFree)) begin
      w_state_d[r_wp] = BankFill;
      w_filling_d     = 1'b1;
      w_s_val_d       = '0;
      w_start_ack_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_state[b] <= BankFree;
        r_tag[b]   <= '0;
      end
      r_wp        <= '0;
      r_rp        <= '0;
      r_cur       <= '0;
      r_cur_vld   <= 1'b0;
      r_prev      <= '0;
      r_prev_vld  <= 1'b0;
      r_filling   <= 1'b0;
      r_s_val     <= '0;
      r_start_ack <= 1'b0;
      r_next_ack  <= 1'b0;
      r_rel_ack   <= 1'b0;
      for (int r = 0; r < NUM_READERS; r++) r_rd_bank[r] <= '0;
      r_rd_ok     <= '0;
    end else begin
      r_state     <= w_state_d;
      if (w_start_ack_d) r_tag[r_wp] <= hs_angle;
      r_wp        <= w_wp_d;
      r_rp        <= w_rp_d;
      r_cur       <= w_cur_d;
      r_cur_vld   <= w_cur_vld_d;
      r_prev      <= w_prev_d;
      r_prev_vld  <= w_prev_vld_d;
      r_filling   <= w_filling_d;
      r_s_val     <= w_s_val_d;
      r_start_ack <= w_start_ack_d;
      r_next_ack  <= w_next_ack_d;
      r_rel_ack   <= w_rel_ack_d;
      // Bank choice is taken from the window as it stands when the address is sampled.
      for (int r = 0; r < NUM_READERS; r++) begin
        r_rd_bank[r] <= pr_sel_prev[r] ? r_prev : r_cur;
        r_rd_ok[r]   <= pr_sel_prev[r] ? r_prev_vld : r_cur_vld;
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) w_we[b] = w_wr && (r_wp == BW'(b));
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    nabp_line_bank #(
      .DEPTH       (DEPTH),
      .DATA_W      (DATA_W),
      .NUM_READERS (NUM_READERS)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_we[b]),
      .i_waddr (r_s_val),
      .i_wdata (hs_val),
      .i_raddr (pr_s_val),
      .o_rdata (w_bank_rdata[b])
    );
  end

  always_comb begin
    pr_val = '0;
    for (int r = 0; r < NUM_READERS; r++) begin
      if (r_rd_ok[r]) pr_val[r*DATA_W +: DATA_W] = w_bank_rdata[r_rd_bank[r]][r*DATA_W +: DATA_W];
    end
  end

  assign hs_start_ack              = r_start_ack;
  assign hs_s_val                  = r_s_val;
  assign hs_line_done              = w_last;
  assign pr_has_next_angle         = (r_state[r_rp] == BankFull);
  assign pr_angle                  = pr_has_next_angle ? r_tag[r_rp] : '0;
  assign pr_next_angle_ack         = r_next_ack;
  assign pr_prev_angle_release_ack = r_rel_ack;

endmodule

// File: tb/tb_nabp_filtered_ring_buffer.sv
// Bench for the filtered ring buffer: a 3-bank/2-reader and a 2-bank/4-reader
// instance, each checked against a queue-level model of the bank ring.
module tb_nabp_filtered_ring_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 16;
  localparam int unsigned ANW   = 9;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic           start [2];
  logic [ANW-1:0] ang [2];
  logic           valid [2];
  logic [DW-1:0]  val [2];
  logic           nxt [2];
  logic           rel [2];
  logic [AW-1:0]  sidx [2][4];
  logic           sel [2][4];

  logic           sack [2];
  logic [AW-1:0]  sv [2];
  logic           ldone [2];
  logic           hasn [2];
  logic [ANW-1:0] pang [2];
  logic           nack [2];
  logic           rack [2];
  logic [DW-1:0]  pv [2][4];

  logic a_sack, a_ldone, a_hasn, a_nack, a_rack;
  logic b_sack, b_ldone, b_hasn, b_nack, b_rack;
  logic [AW-1:0] a_sv, b_sv;
  logic [ANW-1:0] a_pang, b_pang;
  logic [2*AW-1:0] a_ps;
  logic [4*AW-1:0] b_ps;
  logic [1:0] a_sel;
  logic [3:0] b_sel;
  logic [2*DW-1:0] a_pv;
  logic [4*DW-1:0] b_pv;

  always_comb begin
    a_ps  = {sidx[0][1], sidx[0][0]};
    a_sel = {sel[0][1], sel[0][0]};
    b_ps  = {sidx[1][3], sidx[1][2], sidx[1][1], sidx[1][0]};
    b_sel = {sel[1][3], sel[1][2], sel[1][1], sel[1][0]};
    sack[0] = a_sack;   sack[1] = b_sack;
    sv[0] = a_sv;       sv[1] = b_sv;
    ldone[0] = a_ldone; ldone[1] = b_ldone;
    hasn[0] = a_hasn;   hasn[1] = b_hasn;
    pang[0] = a_pang;   pang[1] = b_pang;
    nack[0] = a_nack;   nack[1] = b_nack;
    rack[0] = a_rack;   rack[1] = b_rack;
    pv[0][0] = a_pv[15:0];
    pv[0][1] = a_pv[31:16];
    pv[0][2] = '0;
    pv[0][3] = '0;
    for (int r = 0; r < 4; r++) pv[1][r] = b_pv[r*DW +: DW];
  end

  nabp_filtered_ring_buffer #(
    .NUM_BANKS(3), .DEPTH(DEPTH), .DATA_W(DW), .ANGLE_W(ANW), .NUM_READERS(2)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .hs_start(start[0]), .hs_angle(ang[0]), .hs_start_ack(a_sack),
    .hs_valid(valid[0]), .hs_val(val[0]), .hs_s_val(a_sv), .hs_line_done(a_ldone),
    .pr_has_next_angle(a_hasn), .pr_angle(a_pang),
    .pr_next_angle(nxt[0]), .pr_next_angle_ack(a_nack),
    .pr_prev_angle_release(rel[0]), .pr_prev_angle_release_ack(a_rack),
    .pr_s_val(a_ps), .pr_sel_prev(a_sel), .pr_val(a_pv)
  );

  nabp_filtered_ring_buffer #(
    .NUM_BANKS(2), .DEPTH(DEPTH), .DATA_W(DW), .ANGLE_W(ANW), .NUM_READERS(4)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .hs_start(start[1]), .hs_angle(ang[1]), .hs_start_ack(b_sack),
    .hs_valid(valid[1]), .hs_val(val[1]), .hs_s_val(b_sv), .hs_line_done(b_ldone),
    .pr_has_next_angle(b_hasn), .pr_angle(b_pang),
    .pr_next_angle(nxt[1]), .pr_next_angle_ack(b_nack),
    .pr_prev_angle_release(rel[1]), .pr_prev_angle_release_ack(b_rack),
    .pr_s_val(b_ps), .pr_sel_prev(b_sel), .pr_val(b_pv)
  );

  // Model: banks are handed out in ring order, so the k-th line ever started lands
  // in bank k mod N and the k-th take picks bank k mod N.
  int m_fills [2], m_takes [2], m_occ [2], m_nfull [2], m_widx [2], m_cur [2], m_prev [2];
  bit m_filling [2];
  logic [DW-1:0]  m_data [2][3][DEPTH];
  logic [ANW-1:0] m_tag [2][3];

  int checks = 0;
  int errors = 0;

  function automatic int nb(input int u);
    return (u == 0) ? 3 : 2;
  endfunction

  function automatic int nr(input int u);
    return (u == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_fills[u] = 0; m_takes[u] = 0; m_occ[u] = 0; m_nfull[u] = 0;
      m_widx[u] = 0; m_cur[u] = -1; m_prev[u] = -1; m_filling[u] = 0;
      start[u] = 0; ang[u] = '0; valid[u] = 0; val[u] = '0; nxt[u] = 0; rel[u] = 0;
      for (int r = 0; r < 4; r++) begin
        sidx[u][r] = '0;
        sel[u][r]  = 0;
      end
    end
  endtask

  task automatic chk_zero(input int u);
    chk("rst_start_ack", sack[u], 0);
    chk("rst_s_val", sv[u], 0);
    chk("rst_line_done", ldone[u], 0);
    chk("rst_has_next", hasn[u], 0);
    chk("rst_angle", pang[u], 0);
    chk("rst_next_ack", nack[u], 0);
    chk("rst_rel_ack", rack[u], 0);
    for (int r = 0; r < nr(u); r++) chk("rst_pr_val", pv[u][r], 0);
  endtask

  // One clock of unit u with the inputs already driven; predicts then checks.
  task automatic cycle(input int u);
    int n, b, pprev;
    bit eg, et;
    logic [DW-1:0] epv [4];
    n = nb(u);
    #1;
    chk("line_done", ldone[u], (m_filling[u] && valid[u] && m_widx[u] == DEPTH - 1));
    chk("s_val", sv[u], m_filling[u] ? m_widx[u] : 0);
    for (int r = 0; r < 4; r++) begin
      b = sel[u][r] ? m_prev[u] : m_cur[u];
      epv[r] = (b < 0) ? '0 : m_data[u][b][sidx[u][r]];
    end
    pprev = (rel[u]) ? -1 : m_prev[u];
    eg = start[u] && !m_filling[u] && (m_occ[u] < n);
    et = nxt[u] && (m_nfull[u] > 0) && (pprev < 0);
    @(posedge clk);
    #1;
    if (rel[u] && m_prev[u] >= 0) begin
      m_occ[u]--;
      m_prev[u] = -1;
    end
    if (et) begin
      if (m_cur[u] >= 0) m_prev[u] = m_cur[u];
      m_cur[u] = m_takes[u] % n;
      m_takes[u]++;
      m_nfull[u]--;
    end
    if (eg) begin
      m_tag[u][m_fills[u] % n] = ang[u];
      m_fills[u]++;
      m_occ[u]++;
      m_filling[u] = 1;
      m_widx[u] = 0;
    end else if (m_filling[u] && valid[u]) begin
      m_data[u][(m_fills[u] - 1) % n][m_widx[u]] = val[u];
      m_widx[u]++;
      if (m_widx[u] == DEPTH) begin
        m_widx[u] = 0;
        m_filling[u] = 0;
        m_nfull[u]++;
      end
    end
    chk("start_ack", sack[u], eg);
    chk("next_ack", nack[u], et);
    chk("rel_ack", rack[u], rel[u]);
    chk("has_next", hasn[u], (m_nfull[u] > 0));
    chk("angle", pang[u], (m_nfull[u] > 0) ? m_tag[u][m_takes[u] % n] : '0);
    for (int r = 0; r < nr(u); r++) chk("pr_val", pv[u][r], epv[r]);
  endtask

  task automatic fill(input int u, input int angle, input bit ramp, input bit gaps);
    start[u] = 1;
    ang[u] = ANW'(angle);
    cycle(u);
    start[u] = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        valid[u] = 0;
        cycle(u);
      end
      valid[u] = 1;
      val[u] = ramp ? DW'(i + 1) : DW'($urandom);
      cycle(u);
    end
    valid[u] = 0;
  endtask

  task automatic req(input int u, input bit t, input bit rl);
    nxt[u] = t;
    rel[u] = rl;
    cycle(u);
    nxt[u] = 0;
    rel[u] = 0;
  endtask

  task automatic rd(input int u);
    for (int r = 0; r < 4; r++) begin
      sidx[u][r] = AW'($urandom);
      sel[u][r]  = 1'($urandom);
    end
    cycle(u);
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    #1;
    chk_zero(0);
    chk_zero(1);
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  initial begin
    model_reset();
    #1;
    chk_zero(0);
    chk_zero(1);
    @(posedge clk);
    #1;
    reset_n = 1;

    // Single line, angle 5, ramp data 1..8.
    fill(0, 5, 1, 0);
    req(0, 1, 0);
    sidx[0][0] = 3'd7; sel[0][0] = 0;
    sidx[0][1] = 3'd0; sel[0][1] = 0;
    cycle(0);

    // Ring full, held start stalls, take/take/read, stalled take, release+take.
    do_reset();
    fill(0, 1, 0, 0);
    fill(0, 2, 0, 1);
    fill(0, 3, 0, 0);
    start[0] = 1;
    ang[0] = 9'd4;
    cycle(0);
    cycle(0);
    req(0, 1, 0);
    req(0, 1, 0);
    sidx[0][0] = 3'd3; sel[0][0] = 1;
    sidx[0][1] = 3'd3; sel[0][1] = 0;
    cycle(0);
    req(0, 1, 0);
    req(0, 1, 1);
    cycle(0);
    start[0] = 0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[0] = 1;
      val[0] = DW'($urandom);
      cycle(0);
    end
    valid[0] = 0;
    rd(0);
    rd(0);

    // Reset in the middle of a fill.
    do_reset();
    fill(0, 7, 0, 0);
    start[0] = 1;
    ang[0] = 9'd8;
    req(0, 1, 0);
    start[0] = 0;
    for (int i = 0; i < 4; i++) begin
      valid[0] = 1;
      val[0] = DW'($urandom);
      cycle(0);
    end
    #1;
    chk("s_val_before_reset", sv[0], 4);
    reset_n = 0;
    #1;
    chk_zero(0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
    fill(0, 9, 0, 0);
    req(0, 1, 0);
    rd(0);

    // Two banks, four readers: ten angles around the ring.
    for (int k = 0; k < 10; k++) begin
      req(1, 0, 1);
      fill(1, 20 + k, 0, 1);
      req(1, 1, 0);
      rd(1);
    end

    // Random traffic on both instances.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 400; i++) begin
        start[u] = ($urandom_range(0, 3) == 0);
        ang[u]   = ANW'($urandom);
        valid[u] = ($urandom_range(0, 2) != 0);
        val[u]   = DW'($urandom);
        nxt[u]   = ($urandom_range(0, 3) == 0);
        rel[u]   = ($urandom_range(0, 5) == 0);
        for (int r = 0; r < 4; r++) begin
          sidx[u][r] = AW'($urandom);
          sel[u][r]  = 1'($urandom);
        end
        cycle(u);
      end
      start[u] = 0; valid[u] = 0; nxt[u] = 0; rel[u] = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
